// File: rtl/rf_write_sched.sv
// Write-port scheduler for a 31-entry register file (r0 hard-wired zero).
// Owns the single write port, shares it between requesters A and B with
// round-robin arbitration, and runs an initialisation sweep that loads
// every register rk with the value k after reset and on command.
module rf_write_sched #(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 5
) (
   input  logic          Clock,
   input  logic          Reset,
   input  logic          init_req,
   output logic          init_busy,
   input  logic          a_valid,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_data,
   output logic          a_ready,
   input  logic          b_valid,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_data,
   output logic          b_ready,
   output logic [AW-1:0] Rw,
   output logic [DW-1:0] Data,
   output logic          Write
);

   localparam logic [AW-1:0] CNT_FIRST = AW'(1);
   localparam logic [AW-1:0] CNT_LAST  = {AW{1'b1}};
   localparam logic [AW-1:0] ADDR_ZERO = '0;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t        state;
   logic [AW-1:0] cnt;
   logic          last_b;     // 1: B held the most recent grant
   logic          arb_en;
   logic          grant_a;
   logic          grant_b;
   logic [AW-1:0] gnt_addr;
   logic [DW-1:0] gnt_data;

   // Round-robin grant; readies see only state, last, init_req and valids
   always_comb begin
      arb_en   = (state == ST_RUN) && !init_req;
      grant_a  = arb_en && a_valid && (!b_valid || last_b);
      grant_b  = arb_en && b_valid && (!a_valid || !last_b);
      gnt_addr = grant_b ? b_addr : a_addr;
      gnt_data = grant_b ? b_data : a_data;
   end

   assign a_ready   = grant_a;
   assign b_ready   = grant_b;
   assign init_busy = (state == ST_INIT);

   // State, sweep counter, arbitration history and registered write port
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state  <= ST_INIT;
         cnt    <= CNT_FIRST;
         last_b <= 1'b1;
         Write  <= 1'b0;
         Rw     <= '0;
         Data   <= '0;
      end else begin
         case (state)
            ST_INIT: begin
               Write <= 1'b1;
               Rw    <= cnt;
               Data  <= DW'(cnt);
               cnt   <= cnt + AW'(1);
               if (cnt == CNT_LAST) begin
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               Write <= 1'b0;
               if (init_req) begin
                  state <= ST_INIT;
                  cnt   <= CNT_FIRST;
               end else if (grant_a || grant_b) begin
                  last_b <= grant_b;
                  // r0 writes complete the handshake but never reach the file
                  if (gnt_addr != ADDR_ZERO) begin
                     Write <= 1'b1;
                     Rw    <= gnt_addr;
                     Data  <= gnt_data;
                  end
               end
            end
            default: begin
               state <= ST_INIT;
               cnt   <= CNT_FIRST;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rf_write_sched.sv
// Scoreboard bench for rf_write_sched: a reference model predicts readies
// and each cycle's write-port contents; a separate monitor compares them,
// and both sides keep a register-file image that is compared at the end.
module tb_rf_write_sched;

   localparam int DW   = 32;
   localparam int AW   = 5;
   localparam int NREG = (1 << AW) - 1;

   typedef struct {
      logic          w;
      logic [AW-1:0] rw;
      logic [DW-1:0] d;
   } exp_t;

   logic          Clock;
   logic          Reset;
   logic          init_req;
   logic          init_busy;
   logic          a_valid;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_data;
   logic          a_ready;
   logic          b_valid;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_data;
   logic          b_ready;
   logic [AW-1:0] Rw;
   logic [DW-1:0] Data;
   logic          Write;

   int checks = 0;
   int errors = 0;

   exp_t          q[$];
   int            sweep_q[$];
   logic [DW-1:0] exp_rf[NREG+1];
   logic [DW-1:0] obs_rf[NREG+1];
   bit            m_last_b;
   logic [AW-1:0] m_rw;
   logic [DW-1:0] m_data;
   bit            a_fire;
   bit            b_fire;

   rf_write_sched #(.DW(DW), .AW(AW)) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .init_req (init_req),
      .init_busy(init_busy),
      .a_valid  (a_valid),
      .a_addr   (a_addr),
      .a_data   (a_data),
      .a_ready  (a_ready),
      .b_valid  (b_valid),
      .b_addr   (b_addr),
      .b_data   (b_data),
      .b_ready  (b_ready),
      .Rw       (Rw),
      .Data     (Data),
      .Write    (Write)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: evaluated just before each rising edge
   always @(negedge Clock) begin : model
      exp_t e;
      int   win;
      logic [AW-1:0] ga;
      logic [DW-1:0] gd;
      a_fire = 1'b0;
      b_fire = 1'b0;
      e = '{1'b0, m_rw, m_data};
      if (Reset !== 1'b1) begin
         sweep_q.delete();
         for (int k = 1; k <= NREG; k++) sweep_q.push_back(k);
         m_last_b = 1'b1;
         m_rw     = '0;
         m_data   = '0;
         e        = '{1'b0, '0, '0};
      end else begin
         chk("init_busy", DW'(init_busy), DW'(sweep_q.size() != 0));
         win = 0;
         if (sweep_q.size() == 0 && !init_req) begin
            if (a_valid && b_valid) win = m_last_b ? 1 : 2;
            else if (a_valid)       win = 1;
            else if (b_valid)       win = 2;
         end
         chk("a_ready", DW'(a_ready), DW'(win == 1));
         chk("b_ready", DW'(b_ready), DW'(win == 2));
         a_fire = a_valid && a_ready;
         b_fire = b_valid && b_ready;
         if (sweep_q.size() != 0) begin
            int k;
            k = sweep_q.pop_front();
            e = '{1'b1, AW'(k), DW'(k)};
         end else if (init_req) begin
            for (int k = 1; k <= NREG; k++) sweep_q.push_back(k);
         end else if (win != 0) begin
            m_last_b = (win == 2);
            ga = (win == 1) ? a_addr : b_addr;
            gd = (win == 1) ? a_data : b_data;
            if (ga != '0) e = '{1'b1, ga, gd};
         end
         if (e.w) begin
            m_rw         = e.rw;
            m_data       = e.d;
            exp_rf[e.rw] = e.d;
         end
      end
      q.push_back(e);
   end

   // Monitor: compares the write port after every rising edge
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge Clock);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({Write, Rw, Data} !== {e.w, e.rw, e.d}) begin
               errors++;
               $display("FAIL port: got Write=%b Rw=%0d Data=%h expected Write=%b Rw=%0d Data=%h at %0t",
                        Write, Rw, Data, e.w, e.rw, e.d, $time);
            end
            if (Write === 1'b1) obs_rf[Rw] = Data;
         end
      end
   end

   task automatic tick();
      @(posedge Clock);
      #1;
      if (a_fire) a_valid = 1'b0;
      if (b_fire) b_valid = 1'b0;
      init_req = 1'b0;
   endtask

   initial begin : stim
      for (int i = 0; i <= NREG; i++) begin
         exp_rf[i] = '0;
         obs_rf[i] = '0;
      end
      Reset = 1'b0; init_req = 1'b0;
      a_valid = 1'b0; a_addr = '0; a_data = '0;
      b_valid = 1'b0; b_addr = '0; b_data = '0;

      // Reset and power-up sweep
      repeat (3) tick();
      Reset = 1'b1;
      repeat (33) tick();

      // Sustained contention
      repeat (4) begin
         a_valid = 1'b1; a_addr = AW'(5); a_data = 32'hAAAA_0000;
         b_valid = 1'b1; b_addr = AW'(6); b_data = 32'hBBBB_0000;
         tick();
      end
      a_valid = 1'b0; b_valid = 1'b0;
      tick();

      // Single requester
      b_valid = 1'b1; b_addr = AW'(7); b_data = 32'h1234_5678;
      tick(); tick();

      // r0 write then contention: B must win first
      a_valid = 1'b1; a_addr = '0; a_data = 32'hFFFF_FFFF;
      tick();
      a_valid = 1'b1; a_addr = AW'(8); a_data = 32'h0808_0808;
      b_valid = 1'b1; b_addr = AW'(9); b_data = 32'h0909_0909;
      tick(); tick(); tick();

      // Re-init with A pending, plus an ignored mid-sweep init_req
      a_valid = 1'b1; a_addr = AW'(10); a_data = 32'hDEAD_BEEF;
      init_req = 1'b1;
      tick();
      repeat (10) tick();
      init_req = 1'b1;
      tick();
      repeat (25) tick();

      // Mid-sweep reset after r10 is written
      init_req = 1'b1;
      tick();
      repeat (10) tick();
      Reset = 1'b0;
      tick(); tick();
      Reset = 1'b1;
      repeat (33) tick();

      // Randomized traffic with occasional re-init
      repeat (2000) begin
         if (!a_valid && $urandom_range(0, 2) == 0) begin
            a_valid = 1'b1;
            a_addr  = AW'($urandom_range(0, NREG));
            a_data  = $urandom;
         end
         if (!b_valid && $urandom_range(0, 2) == 0) begin
            b_valid = 1'b1;
            b_addr  = ($urandom_range(0, 1) == 0) ? a_addr : AW'($urandom_range(0, NREG));
            b_data  = $urandom;
         end
         init_req = ($urandom_range(0, 199) == 0);
         tick();
      end
      a_valid = 1'b0; b_valid = 1'b0;
      repeat (40) tick();

      @(posedge Clock);
      #3;
      chk("queue_drained", DW'(q.size()), '0);
      for (int i = 1; i <= NREG; i++) chk($sformatf("rf_r%0d", i), obs_rf[i], exp_rf[i]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
